spram_arbiter: RTL and testbench
================================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: SPRAM word-address width.
REQ-002 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = port 0 always wins a tie.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_valid / m1_valid  input  1  request from port 0 (CPU) / port 1 (DMA).
REQ-006 m0_ready / m1_ready  output  1  one-cycle completion pulse for that port.
REQ-007 m0_addr / m1_addr  input  ADDR_W  word address.
REQ-008 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-009 m0_wdata / m1_wdata  input  32  write data.
REQ-010 m0_rdata / m1_rdata  output  32  read data, valid while that port's ready is high.
REQ-011 ram_sel  output  1  SPRAM select.
REQ-012 ram_we  output  4  SPRAM byte write enables.
REQ-013 ram_addr  output  ADDR_W  SPRAM address.
REQ-014 ram_wdat  output  32  SPRAM write data.
REQ-015 ram_rdat  input  32  SPRAM read data, registered, valid the cycle after ram_sel.
REQ-016 conflict_cnt  output  16  saturating count of cycles in which a port held valid but was not granted.

Function
REQ-017 States: IDLE, ACCESS, RESP. One grant register `gnt` (0/1) and one last-served pointer `last`.
REQ-018 IDLE: no valid -> stay. One valid -> grant it, go ACCESS. Both valid -> grant !last (round-robin) or 0 (FIXED_PRIO=1), go ACCESS.
REQ-019 ACCESS: ram_sel=1; ram_we/addr/wdat driven from granted port's inputs; go RESP unconditionally.
REQ-020 RESP: granted port's ready=1 for exactly one cycle; its rdata=ram_rdat; last<=gnt.
REQ-021 RESP: if the non-granted port is valid, grant it and go ACCESS directly; otherwise go IDLE. The just-served port is never regranted from RESP.
REQ-022 Resulting latency: valid in IDLE at cycle N -> ram_sel at N+1 -> ready at N+2. Back-to-back alternating service completes one access per 2 cycles.
REQ-023 Masters hold addr/wstrb/wdata stable while valid and not ready. The arbiter does not register master request fields.
REQ-024 Outside ACCESS: ram_sel=0, ram_we=0. ram_addr/ram_wdat follow the granted port (don't-care when unselected).
REQ-025 ready never asserts for the non-granted port. Both readies are never high together.
REQ-026 m*_rdata drive ram_rdat when that port's ready is high, else 0.
REQ-027 A port that drops valid before being granted is simply not served. No request is latched.
REQ-028 conflict_cnt increments by 1 each cycle a port has valid=1 and is not the port being served in ACCESS/RESP (both ports stalled = +1, not +2). It holds at 16'hFFFF.
REQ-029 Writes with wstrb=0 are reads. Any nonzero wstrb passes through unchanged (partial-byte writes allowed).

Reset
REQ-030 When rst is sampled high: state=IDLE, gnt=0, last=1 (port 0 wins the first tie), conflict_cnt=0. All outputs read 0 in the following cycle.
REQ-031 Reset asserted in ACCESS or RESP abandons the access: no ready pulse is issued and no further ram_sel follows.

Structure
REQ-032 Shared package spram_arb_pkg holds the state enumeration (IDLE, ACCESS, RESP) and the 2-way pick function (valid pair, last, FIXED_PRIO -> winner).
REQ-033 No sub-module: a single flat module with one FSM, one pointer register and one counter.

Verification
REQ-034 Single read: m0_valid, addr=0x0010, wstrb=0, RAM returns 0xDEADBEEF -> ram_sel at N+1, m0_ready at N+2, m0_rdata=0xDEADBEEF, conflict_cnt=0.
REQ-035 Simultaneous first requests: both valid at N after reset -> m0 served (ready N+2), m1 ACCESS N+3, m1_ready N+4, conflict_cnt=2.
REQ-036 Round-robin under saturation: both continuously valid for 8 grants -> order 0,1,0,1,0,1,0,1. With FIXED_PRIO=1 and m0 re-requesting in the RESP cycle -> still alternates, per REQ-021.
REQ-037 Byte write: m1 writes wstrb=4'b0100, wdata=0x00AB0000, addr=0x3FFF -> ram_we=4'b0100 and ram_addr=0x3FFF for exactly one cycle; ram_we=0 in all other cycles.
REQ-038 Reset mid-access: rst high during ACCESS -> no m*_ready pulse, ram_sel=0 next cycle, conflict_cnt=0, then a subsequent tie is granted to port 0.
REQ-039 Saturation: hold m1 stalled behind continuous m0 traffic (FIXED_PRIO=1, forced via stuck m1 in test hook) for 70000 cycles -> conflict_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types and the two-way pick used by the SPRAM arbiter.
package spram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Winner of a request pair: a tie goes to port 0 in fixed mode, else to the port not served last.
   function automatic logic pick(input logic v0, input logic v1, input logic last, input logic fixed);
      logic w;
      if (v0 && v1) begin
         w = fixed ? 1'b0 : ~last;
      end else begin
         w = v1;
      end
      return w;
   endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Two master request ports plus the SPRAM side, shared by arbiter and environment.
interface spram_arb_if #(
   parameter int unsigned ADDR_W = 14
) ();
   logic              m0_valid;
   logic              m0_ready;
   logic [ADDR_W-1:0] m0_addr;
   logic [3:0]        m0_wstrb;
   logic [31:0]       m0_wdata;
   logic [31:0]       m0_rdata;

   logic              m1_valid;
   logic              m1_ready;
   logic [ADDR_W-1:0] m1_addr;
   logic [3:0]        m1_wstrb;
   logic [31:0]       m1_wdata;
   logic [31:0]       m1_rdata;

   logic              ram_sel;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdat;
   logic [31:0]       ram_rdat;

   // Environment side: issues requests and models the SPRAM.
   modport master (
      output m0_valid, m0_addr, m0_wstrb, m0_wdata,
      input  m0_ready, m0_rdata,
      output m1_valid, m1_addr, m1_wstrb, m1_wdata,
      input  m1_ready, m1_rdata,
      input  ram_sel, ram_we, ram_addr, ram_wdat,
      output ram_rdat
   );

   // Arbiter side.
   modport slave (
      input  m0_valid, m0_addr, m0_wstrb, m0_wdata,
      output m0_ready, m0_rdata,
      input  m1_valid, m1_addr, m1_wstrb, m1_wdata,
      output m1_ready, m1_rdata,
      output ram_sel, ram_we, ram_addr, ram_wdat,
      input  ram_rdat
   );
endinterface

// File: rtl/spram_arbiter.sv
// Two-port arbiter sharing one single-port RAM between a CPU (port 0) and a DMA (port 1).
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 14,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   spram_arb_if.slave   bus,
   output logic [15:0]  conflict_cnt
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   state_t            r_state;
   logic              r_gnt;
   logic              r_last;
   logic              r_sel;
   logic [1:0]        r_rdy;
   logic [15:0]       r_cnt;

   logic              w_other_valid;
   logic              w_stall;
   logic [ADDR_W-1:0] w_addr;

   // Non-granted port's request; only meaningful while a grant is active.
   assign w_other_valid = r_gnt ? bus.m0_valid : bus.m1_valid;
   assign w_stall       = (r_state != IDLE) && w_other_valid;

   // Arbitration FSM, grant/last pointers and the saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
         r_sel   <= 1'b0;
         r_rdy   <= 2'b00;
         r_cnt   <= 16'd0;
      end else begin
         r_sel <= 1'b0;
         r_rdy <= 2'b00;
         case (r_state)
            IDLE: begin
               if (bus.m0_valid || bus.m1_valid) begin
                  r_gnt   <= pick(bus.m0_valid, bus.m1_valid, r_last, FIXED_PRIO);
                  r_sel   <= 1'b1;
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               r_rdy   <= r_gnt ? 2'b10 : 2'b01;
               r_state <= RESP;
            end
            RESP: begin
               r_last <= r_gnt;
               // Hand over directly to the waiting port; the served port is never regranted here.
               if (w_other_valid) begin
                  r_gnt   <= ~r_gnt;
                  r_sel   <= 1'b1;
                  r_state <= ACCESS;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_stall && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   // Request fields are taken straight from the granted master, which holds them stable.
   assign w_addr       = r_gnt ? bus.m1_addr : bus.m0_addr;
   assign bus.ram_addr = w_addr;
   assign bus.ram_wdat = r_gnt ? bus.m1_wdata : bus.m0_wdata;
   assign bus.ram_we   = r_sel ? (r_gnt ? bus.m1_wstrb : bus.m0_wstrb) : 4'b0000;
   assign bus.ram_sel  = r_sel;

   // Completion pulses and read data gated to the served port.
   assign bus.m0_ready = r_rdy[0];
   assign bus.m1_ready = r_rdy[1];
   assign bus.m0_rdata = r_rdy[0] ? bus.ram_rdat : 32'd0;
   assign bus.m1_rdata = r_rdy[1] ? bus.ram_rdat : 32'd0;

   assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters side by side.
module tb_spram_arbiter;
   import spram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   int          n_chk  = 0;
   int          n_fail = 0;

   spram_arb_if #(.ADDR_W(14)) bus_a ();
   spram_arb_if #(.ADDR_W(14)) bus_b ();

   spram_arbiter #(.ADDR_W(14), .FIXED_PRIO(1'b0)) u_rr (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_a.slave),
      .conflict_cnt (cnt_a)
   );

   spram_arbiter #(.ADDR_W(14), .FIXED_PRIO(1'b1)) u_fp (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_b.slave),
      .conflict_cnt (cnt_b)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_model(input logic [13:0] a);
      return (a == 14'h0010) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
   endfunction

   // Registered SPRAM read models, one per arbiter.
   always @(posedge clk) if (bus_a.ram_sel) bus_a.ram_rdat <= rd_model(bus_a.ram_addr);
   always @(posedge clk) if (bus_b.ram_sel) bus_b.ram_rdat <= rd_model(bus_b.ram_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.m0_valid = 1'b0; bus_a.m0_addr = '0; bus_a.m0_wstrb = '0; bus_a.m0_wdata = '0;
      bus_a.m1_valid = 1'b0; bus_a.m1_addr = '0; bus_a.m1_wstrb = '0; bus_a.m1_wdata = '0;
      bus_b.m0_valid = 1'b0; bus_b.m0_addr = '0; bus_b.m0_wstrb = '0; bus_b.m0_wdata = '0;
      bus_b.m1_valid = 1'b0; bus_b.m1_addr = '0; bus_b.m1_wstrb = '0; bus_b.m1_wdata = '0;
      bus_a.ram_rdat = '0;
      bus_b.ram_rdat = '0;

      // Reset state
      tick();
      tick();
      chk("rst_sel",   32'(bus_a.ram_sel), 32'd0);
      chk("rst_we",    32'(bus_a.ram_we), 32'd0);
      chk("rst_ready", 32'({bus_a.m1_ready, bus_a.m0_ready}), 32'd0);
      chk("rst_rdata", bus_a.m0_rdata | bus_a.m1_rdata, 32'd0);
      chk("rst_cnt",   32'(cnt_a), 32'd0);
      rst = 1'b0;
      tick();

      // Single read on port 0
      bus_a.m0_valid = 1'b1; bus_a.m0_addr = 14'h0010; bus_a.m0_wstrb = 4'h0;
      tick();
      chk("rd_sel_n1",   32'(bus_a.ram_sel), 32'd1);
      chk("rd_addr_n1",  32'(bus_a.ram_addr), 32'h0010);
      chk("rd_we_n1",    32'(bus_a.ram_we), 32'd0);
      chk("rd_rdy_n1",   32'(bus_a.m0_ready), 32'd0);
      tick();
      chk("rd_rdy_n2",   32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b01);
      chk("rd_rdata_n2", bus_a.m0_rdata, 32'hDEADBEEF);
      chk("rd_sel_n2",   32'(bus_a.ram_sel), 32'd0);
      bus_a.m0_valid = 1'b0;
      tick();
      chk("rd_rdy_n3",   32'(bus_a.m0_ready), 32'd0);
      chk("rd_cnt",      32'(cnt_a), 32'd0);

      // Simultaneous first requests after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus_a.m0_valid = 1'b1; bus_a.m0_addr = 14'h0020;
      bus_a.m1_valid = 1'b1; bus_a.m1_addr = 14'h0030; bus_a.m1_wstrb = 4'h0;
      tick();
      chk("tie_addr_n1",  32'(bus_a.ram_addr), 32'h0020);
      tick();
      chk("tie_rdy_n2",   32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b01);
      chk("tie_rdata_n2", bus_a.m0_rdata, 32'hC0DE0020);
      bus_a.m0_valid = 1'b0;
      tick();
      chk("tie_sel_n3",   32'(bus_a.ram_sel), 32'd1);
      chk("tie_addr_n3",  32'(bus_a.ram_addr), 32'h0030);
      chk("tie_rdy_n3",   32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b00);
      tick();
      chk("tie_rdy_n4",   32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b10);
      chk("tie_rdata_n4", bus_a.m1_rdata, 32'hC0DE0030);
      bus_a.m1_valid = 1'b0;
      tick();
      chk("tie_cnt",      32'(cnt_a), 32'd2);

      // Byte write on port 1
      bus_a.m1_valid = 1'b1; bus_a.m1_addr = 14'h3FFF;
      bus_a.m1_wstrb = 4'b0100; bus_a.m1_wdata = 32'h00AB0000;
      chk("wr_we_n0",   32'(bus_a.ram_we), 32'd0);
      tick();
      chk("wr_we_n1",   32'(bus_a.ram_we), 32'b0100);
      chk("wr_addr_n1", 32'(bus_a.ram_addr), 32'h3FFF);
      chk("wr_wdat_n1", bus_a.ram_wdat, 32'h00AB0000);
      tick();
      chk("wr_we_n2",   32'(bus_a.ram_we), 32'd0);
      chk("wr_rdy_n2",  32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b10);
      bus_a.m1_valid = 1'b0; bus_a.m1_wstrb = 4'h0;
      tick();
      chk("wr_we_n3",   32'(bus_a.ram_we), 32'd0);

      // Round-robin under saturation: ready on even cycles, alternating 0,1,0,1...
      bus_a.m0_valid = 1'b1; bus_a.m0_addr = 14'h0100;
      bus_a.m1_valid = 1'b1; bus_a.m1_addr = 14'h0200;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if ((k % 2) == 0) begin
            chk("rr_order", 32'({bus_a.m1_ready, bus_a.m0_ready}),
                ((((k / 2) - 1) % 2) == 1) ? 32'b10 : 32'b01);
         end else begin
            chk("rr_gap", 32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b00);
         end
      end
      chk("rr_cnt", 32'(cnt_a), 32'd17);
      bus_a.m0_valid = 1'b0;
      bus_a.m1_valid = 1'b0;
      tick();
      tick();

      // Reset in the middle of an access
      bus_a.m1_valid = 1'b1; bus_a.m1_addr = 14'h0050;
      tick();
      chk("mid_sel_pre", 32'(bus_a.ram_sel), 32'd1);
      rst = 1'b1;
      bus_a.m0_valid = 1'b1; bus_a.m0_addr = 14'h0040;
      tick();
      rst = 1'b0;
      chk("mid_rdy",  32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b00);
      chk("mid_sel",  32'(bus_a.ram_sel), 32'd0);
      chk("mid_cnt",  32'(cnt_a), 32'd0);
      tick();
      chk("mid_tie_addr", 32'(bus_a.ram_addr), 32'h0040);
      tick();
      chk("mid_tie_rdy",  32'({bus_a.m1_ready, bus_a.m0_ready}), 32'b01);
      bus_a.m0_valid = 1'b0;
      bus_a.m1_valid = 1'b0;
      tick();

      // Fixed priority: RESP hand-over still alternates
      bus_b.m0_valid = 1'b1; bus_b.m0_addr = 14'h0011;
      bus_b.m1_valid = 1'b1; bus_b.m1_addr = 14'h0022;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if ((k % 2) == 0) begin
            chk("fp_order", 32'({bus_b.m1_ready, bus_b.m0_ready}),
                ((((k / 2) - 1) % 2) == 1) ? 32'b10 : 32'b01);
         end
      end
      chk("fp_cnt", 32'(cnt_b), 32'd15);

      // Saturation of the stall counter
      for (int k = 0; k < 65600; k++) begin
         tick();
      end
      chk("sat_cnt", 32'(cnt_b), 32'h0000FFFF);
      for (int k = 0; k < 5; k++) begin
         tick();
      end
      chk("sat_hold", 32'(cnt_b), 32'h0000FFFF);
      bus_b.m0_valid = 1'b0;
      bus_b.m1_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
